ethernet_phy_manager: RTL and testbench

- Autonomous PHY bring-up and link supervisor directly upstream of ethernet_mac2phy.
- Drives its register interface (address/write/read/data, done handshake):
  - soft-resets the PHY;
  - programs advertisement and restarts auto-negotiation;
  - resolves speed/duplex;
  - monitors link.
- Exposes link/speed/duplex to the MAC and a small arbitrated port for software register access.

---
 rtl/ethernet_phy_manager.sv | 231 +++++++++++++++++++++++
 tb/tb_ethernet_phy_manager.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_phy_manager.sv
// Autonomous PHY bring-up and link supervisor in front of ethernet_mac2phy, with a
// small software register port that is served only between link polls or in error.
module ethernet_phy_manager #(
    parameter int          POLL_CYCLES = 50000,
    parameter int          MAX_POLLS   = 1000,
    parameter logic [15:0] ADVERTISE   = 16'h01E1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [4:0]  address_o,
    output logic        write_o,
    output logic        read_o,
    output logic [15:0] data_o,
    input  logic [15:0] data_i,
    input  logic        done_i,
    input  logic [4:0]  ext_address_i,
    input  logic [15:0] ext_data_i,
    input  logic        ext_write_i,
    input  logic        ext_read_i,
    output logic [15:0] ext_data_o,
    output logic        ext_done_o,
    output logic        link_o,
    output logic        speed_o,
    output logic        duplex_o,
    output logic        error_o
);
    localparam int DLY_W  = $clog2(POLL_CYCLES + 1);
    localparam int POLL_W = $clog2(MAX_POLLS + 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(POLL_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS);

    typedef enum logic [3:0] {
        RST_WR, DLY_R, RST_RD, ANAR_WR, AN_WR, DLY_S,
        STAT_RD, LPA_RD, LINK_UP, LINK_RD, EXT, ERROR
    } state_t;

    state_t             state, state_next;
    logic               busy, busy_next;
    logic [DLY_W-1:0]   dly, dly_next;
    logic [POLL_W-1:0]  poll, poll_next, poll_inc;
    logic               ext_wr, ext_wr_next;
    logic [4:0]         address_next;
    logic [15:0]        data_next, ext_data_next;
    logic               write_next, read_next, ext_done_next;
    logic               link_next, speed_next, duplex_next, error_next;
    logic               acc_go, acc_wr, acc_done, ext_take;
    logic [4:0]         acc_addr;
    logic [15:0]        acc_data;
    logic [3:0]         common;

    // A request is not re-accepted in the cycle its completion pulse is out,
    // giving the requester that cycle to drop its level.
    assign ext_take = (ext_write_i | ext_read_i) & ~ext_done_o;
    assign poll_inc = poll + 1'b1;
    assign common   = data_i[8:5] & ADVERTISE[8:5];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= RST_WR;
            busy       <= 1'b0;
            dly        <= '0;
            poll       <= '0;
            ext_wr     <= 1'b0;
            address_o  <= '0;
            write_o    <= 1'b0;
            read_o     <= 1'b0;
            data_o     <= '0;
            ext_data_o <= '0;
            ext_done_o <= 1'b0;
            link_o     <= 1'b0;
            speed_o    <= 1'b0;
            duplex_o   <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= busy_next;
            dly        <= dly_next;
            poll       <= poll_next;
            ext_wr     <= ext_wr_next;
            address_o  <= address_next;
            write_o    <= write_next;
            read_o     <= read_next;
            data_o     <= data_next;
            ext_data_o <= ext_data_next;
            ext_done_o <= ext_done_next;
            link_o     <= link_next;
            speed_o    <= speed_next;
            duplex_o   <= duplex_next;
            error_o    <= error_next;
        end
    end

    always_comb begin
        state_next    = state;
        busy_next     = busy;
        dly_next      = dly;
        poll_next     = poll;
        ext_wr_next   = ext_wr;
        address_next  = address_o;
        data_next     = data_o;
        write_next    = 1'b0;
        read_next     = 1'b0;
        ext_data_next = ext_data_o;
        ext_done_next = 1'b0;
        link_next     = link_o;
        speed_next    = speed_o;
        duplex_next   = duplex_o;
        error_next    = error_o;
        acc_go        = 1'b0;
        acc_wr        = 1'b0;
        acc_addr      = '0;
        acc_data      = '0;
        // busy is only ever set in access states, so a stray done_i elsewhere is dropped
        acc_done      = busy & done_i;

        case (state)
            RST_WR: begin
                acc_go = 1'b1; acc_wr = 1'b1; acc_data = 16'h8000;
                if (acc_done) state_next = DLY_R;
            end
            DLY_R, DLY_S: begin
                if (dly == DLY_LAST) begin
                    dly_next   = '0;
                    state_next = (state == DLY_R) ? RST_RD : STAT_RD;
                end else begin
                    dly_next = dly + 1'b1;
                end
            end
            RST_RD: begin
                acc_go = 1'b1;
                if (acc_done) begin
                    if (!data_i[15]) begin
                        state_next = ANAR_WR;
                    end else begin
                        poll_next  = poll_inc;
                        state_next = (poll_inc == POLL_LAST) ? ERROR : DLY_R;
                    end
                end
            end
            ANAR_WR: begin
                acc_go = 1'b1; acc_wr = 1'b1; acc_addr = 5'd4; acc_data = ADVERTISE;
                if (acc_done) state_next = AN_WR;
            end
            AN_WR: begin
                acc_go = 1'b1; acc_wr = 1'b1; acc_data = 16'h1200;
                if (acc_done) begin
                    poll_next  = '0;
                    state_next = DLY_S;
                end
            end
            STAT_RD: begin
                acc_go = 1'b1; acc_addr = 5'd1;
                if (acc_done) begin
                    if (data_i[5] && data_i[2]) begin
                        state_next = LPA_RD;
                    end else begin
                        poll_next  = poll_inc;
                        state_next = (poll_inc == POLL_LAST) ? ERROR : DLY_S;
                    end
                end
            end
            LPA_RD: begin
                acc_go = 1'b1; acc_addr = 5'd5;
                if (acc_done) begin
                    state_next = LINK_UP;
                    link_next  = 1'b1;
                    if (common[3])      begin speed_next = 1'b1; duplex_next = 1'b1; end
                    else if (common[2]) begin speed_next = 1'b1; duplex_next = 1'b0; end
                    else if (common[1]) begin speed_next = 1'b0; duplex_next = 1'b1; end
                    else if (common[0]) begin speed_next = 1'b0; duplex_next = 1'b0; end
                    else                state_next = ERROR;
                end
            end
            LINK_UP: begin
                if (ext_take) begin
                    state_next  = EXT;
                    ext_wr_next = ext_write_i;
                end else if (dly == DLY_LAST) begin
                    dly_next   = '0;
                    state_next = LINK_RD;
                end else begin
                    dly_next = dly + 1'b1;
                end
            end
            LINK_RD: begin
                acc_go = 1'b1; acc_addr = 5'd1;
                if (acc_done) begin
                    if (data_i[2]) begin
                        state_next = LINK_UP;
                    end else begin
                        link_next   = 1'b0;
                        speed_next  = 1'b0;
                        duplex_next = 1'b0;
                        poll_next   = '0;
                        state_next  = AN_WR;
                    end
                end
            end
            EXT: begin
                acc_go = 1'b1; acc_wr = ext_wr; acc_addr = ext_address_i; acc_data = ext_data_i;
                if (acc_done) begin
                    ext_done_next = 1'b1;
                    if (!ext_wr) ext_data_next = data_i;
                    state_next = error_o ? ERROR : LINK_UP;
                end
            end
            ERROR: begin
                if (ext_take) begin
                    state_next  = EXT;
                    ext_wr_next = ext_write_i;
                end
            end
            default: state_next = RST_WR;
        endcase

        // Single strobe per access; address/data stay registered until done_i.
        if (acc_go && !busy) begin
            busy_next    = 1'b1;
            write_next   = acc_wr;
            read_next    = ~acc_wr;
            address_next = acc_addr;
            data_next    = acc_data;
        end
        if (acc_go && acc_done) busy_next = 1'b0;

        if (state_next == ERROR) begin
            error_next = 1'b1;
            link_next  = 1'b0;
        end
    end
endmodule

// File: tb/tb_ethernet_phy_manager.sv
// Bench for ethernet_phy_manager: behavioural PHY register file behind the mac2phy
// port, with every expected register transaction queued ahead and checked on strobe.
`timescale 1ns/1ps
module tb_ethernet_phy_manager;
    localparam int POLL = 8;
    localparam int MAXP = 4;
    localparam int LAT  = 2;

    typedef struct packed { logic wr; logic [4:0] addr; logic [15:0] data; } xact_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  address_o;
    logic        write_o, read_o;
    logic [15:0] data_o;
    logic [15:0] data_i = '0;
    logic        done_i = 1'b0;
    logic [4:0]  ext_address_i = '0;
    logic [15:0] ext_data_i = '0;
    logic        ext_write_i = 1'b0, ext_read_i = 1'b0;
    logic [15:0] ext_data_o;
    logic        ext_done_o, link_o, speed_o, duplex_o, error_o;

    int    n_cmp = 0, n_err = 0;
    xact_t sb[$];

    // PHY model state
    logic [15:0] reg1_val = 16'h0024, reg5_val = 16'h05E1;
    bit          stuck = 0, stale_mode = 0, idle_r1_ok = 0;
    int          reg0_reads = 0, reg2_reads = 0, n_strobes = 0, pend = 0, ext_early = 0;
    logic [15:0] pend_data, pend_wdata;
    logic [4:0]  pend_addr, post_addr;
    bit          arm_post = 0, stale_wait = 0, stale_rst = 0;
    logic        lpa_pre, lpa_post, lpa_spd, lpa_dup, r1_pre, r1_post;

    ethernet_phy_manager #(.POLL_CYCLES(POLL), .MAX_POLLS(MAXP), .ADVERTISE(16'h01E1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .address_o(address_o), .write_o(write_o), .read_o(read_o), .data_o(data_o),
        .data_i(data_i), .done_i(done_i),
        .ext_address_i(ext_address_i), .ext_data_i(ext_data_i),
        .ext_write_i(ext_write_i), .ext_read_i(ext_read_i),
        .ext_data_o(ext_data_o), .ext_done_o(ext_done_o),
        .link_o(link_o), .speed_o(speed_o), .duplex_o(duplex_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic wr, input logic [4:0] addr, input logic [15:0] data);
        xact_t x;
        x.wr = wr; x.addr = addr; x.data = data;
        sb.push_back(x);
    endtask

    task automatic push_bringup();
        push(1'b1, 5'd0, 16'h8000);
        repeat (3) push(1'b0, 5'd0, 16'h0000);
        push(1'b1, 5'd4, 16'h01E1);
        push(1'b1, 5'd0, 16'h1200);
        push(1'b0, 5'd1, 16'h0000);
        push(1'b0, 5'd5, 16'h0000);
    endtask

    // PHY model: reacts at negedges, answers every strobe LAT cycles later
    initial begin
        xact_t cur, exp;
        forever begin
            @(negedge clk);
            done_i = 1'b0;
            if (arm_post) begin
                arm_post = 0;
                if (post_addr == 5'd5) begin lpa_post = link_o; lpa_spd = speed_o; lpa_dup = duplex_o; end
                else if (post_addr == 5'd1) r1_post = link_o;
            end
            if (rst_i && !stale_wait) pend = 0;
            if (stale_wait) begin
                // late completion of an aborted read, held across the reset release edge
                if (rst_i) begin
                    if (stale_rst) begin done_i = 1'b1; data_i = 16'h0000; end
                    stale_rst = 1;
                end else if (stale_rst) begin
                    stale_wait = 0; stale_rst = 0;
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    chk("hold_addr", 32'(address_o), 32'(pend_addr));
                    chk("hold_data", 32'(data_o), 32'(pend_wdata));
                    done_i = 1'b1; data_i = pend_data; arm_post = 1; post_addr = pend_addr;
                    if (pend_addr == 5'd5) lpa_pre = link_o;
                    else if (pend_addr == 5'd1) r1_pre = link_o;
                end
            end
            if (write_o || read_o) begin
                n_strobes++;
                if (pend > 0 || stale_wait) chk("overlap_strobe", 32'(pend), 32'd0);
                chk("one_strobe", 32'(write_o & read_o), 32'd0);
                cur.wr = write_o; cur.addr = address_o; cur.data = write_o ? data_o : 16'h0000;
                if (read_o && address_o == 5'd1 && idle_r1_ok) chk("poll_r1", 32'(cur), 32'h0001_0000);
                else if (sb.size() == 0) chk("unexp_strobe", 32'(sb.size()), 32'd1);
                else begin
                    exp = sb.pop_front();
                    chk("xact", 32'(cur), 32'(exp));
                end
                pend = LAT; pend_addr = address_o; pend_wdata = data_o; pend_data = 16'h0000;
                if (write_o) begin
                    if (address_o == 5'd0 && data_o == 16'h8000) reg0_reads = 0;
                end else begin
                    case (address_o)
                        5'd0: begin
                            reg0_reads++;
                            pend_data = (stuck || reg0_reads < 3) ? 16'h9140 : 16'h1140;
                            if (stale_mode) begin stale_mode = 0; stale_wait = 1; stale_rst = 0; pend = 0; end
                        end
                        5'd1: pend_data = reg1_val;
                        5'd2: begin reg2_reads++; pend_data = 16'h0022; end
                        5'd5: pend_data = reg5_val;
                        default: pend_data = 16'h0000;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) if (ext_done_o && !link_o && !error_o) ext_early++;

    // 0: link up, 1: link down, 2: error, 3: ext_done, 4: read strobe to reg0
    task automatic wait_for(input int which, input string tag, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            case (which)
                0: hit = link_o;
                1: hit = !link_o;
                2: hit = error_o;
                3: hit = ext_done_o;
                default: hit = read_o && address_o == 5'd0;
            endcase
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", {data_o, ext_data_o}, 32'd0);
        chk("rst_ctl", 32'({address_o, write_o, read_o, ext_done_o, link_o, speed_o, duplex_o, error_o}), 32'd0);
    endtask

    task automatic idle_check(input string tag);
        int s0 = n_strobes;
        repeat (40) @(negedge clk);
        #1;
        chk(tag, 32'(n_strobes - s0), 32'd0);
    endtask

    initial begin
        // bring-up to 100/full
        do_reset();
        push_bringup();
        rst_i = 1'b0;
        wait_for(0, "bringup_link", 400);
        @(negedge clk); #1;
        idle_r1_ok = 1;
        chk("bu_spd_dup", 32'({link_o, speed_o, duplex_o, error_o}), 32'b1110);
        chk("bu_lpa_edge", 32'({lpa_pre, lpa_post, lpa_spd, lpa_dup}), 32'b0111);
        chk("bu_sb_empty", 32'(sb.size()), 32'd0);

        // software read while link is up
        push(1'b0, 5'd2, 16'h0000);
        ext_address_i = 5'h02; ext_read_i = 1'b1;
        wait_for(3, "ext_rd_done", 200);
        chk("ext_rd_data", 32'(ext_data_o), 32'h0022);
        ext_read_i = 1'b0;
        @(negedge clk); #1;
        chk("ext_done_pulse", 32'(ext_done_o), 32'd0);
        chk("ext_rd_count", 32'(reg2_reads), 32'd1);

        // link drop and recovery
        push(1'b1, 5'd0, 16'h1200);
        push(1'b0, 5'd5, 16'h0000);
        reg1_val = 16'h0020;
        wait_for(1, "link_drop", 200);
        @(negedge clk); #1;
        chk("drop_edge", 32'({r1_pre, r1_post, speed_o, duplex_o}), 32'b1000);
        reg1_val = 16'h0024;
        wait_for(0, "link_restore", 300);
        @(negedge clk); #1;
        chk("restore_spd_dup", 32'({speed_o, duplex_o}), 32'b11);
        chk("restore_sb_empty", 32'(sb.size()), 32'd0);

        // 10/full, software read requested early stays pending until link up
        do_reset();
        reg5_val = 16'h0041; idle_r1_ok = 0; reg2_reads = 0; ext_early = 0;
        push_bringup();
        push(1'b0, 5'd2, 16'h0000);
        rst_i = 1'b0;
        wait_for(4, "rd0_seen", 100);
        ext_address_i = 5'h02; ext_read_i = 1'b1;
        wait_for(3, "late_ext_done", 500);
        chk("late_ext_data", 32'(ext_data_o), 32'h0022);
        chk("ten_full", 32'({link_o, speed_o, duplex_o}), 32'b101);
        ext_read_i = 1'b0;
        idle_r1_ok = 1;
        chk("late_ext_count", 32'(reg2_reads), 32'd1);
        chk("ext_not_early", 32'(ext_early), 32'd0);
        chk("late_sb_empty", 32'(sb.size()), 32'd0);

        // no common mode -> error, software write still served (write wins over read)
        do_reset();
        reg5_val = 16'h0001; idle_r1_ok = 0;
        push_bringup();
        rst_i = 1'b0;
        wait_for(2, "nocommon_err", 400);
        chk("nocommon_link", 32'({link_o, error_o}), 32'b01);
        idle_check("nocommon_idle");
        push(1'b1, 5'h1F, 16'hABCD);
        ext_address_i = 5'h1F; ext_data_i = 16'hABCD; ext_write_i = 1'b1; ext_read_i = 1'b1;
        wait_for(3, "err_ext_done", 100);
        ext_write_i = 1'b0; ext_read_i = 1'b0;
        chk("err_ext_wr_data", 32'({ext_data_o, error_o, link_o}), 32'h0000_0002);
        chk("err_sb_empty", 32'(sb.size()), 32'd0);

        // reg0 reset bit stuck -> exactly MAXP reads then error
        do_reset();
        stuck = 1; reg5_val = 16'h05E1;
        push(1'b1, 5'd0, 16'h8000);
        repeat (MAXP) push(1'b0, 5'd0, 16'h0000);
        rst_i = 1'b0;
        wait_for(2, "stuck_err", 300);
        idle_check("stuck_idle");
        chk("stuck_reads", 32'(reg0_reads), 32'(MAXP));
        chk("stuck_sb_empty", 32'(sb.size()), 32'd0);

        // reset in the middle of a read; late done_i must be ignored
        do_reset();
        stuck = 0; stale_mode = 1;
        push(1'b1, 5'd0, 16'h8000);
        push(1'b0, 5'd0, 16'h0000);
        rst_i = 1'b0;
        wait_for(4, "pre_rst_rd", 100);
        push_bringup();
        do_reset();
        rst_i = 1'b0;
        wait_for(0, "post_rst_link", 400);
        chk("post_rst_spd_dup", 32'({speed_o, duplex_o, error_o}), 32'b110);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
